// File: rtl/lcd_bus_receiver.sv
// Shadow model of a 2x16 character LCD decoding E/RS/RW/DATA write transactions.
// Latency: transaction executes at the edge ending the E-fall cycle; RD_CHAR is 1 cycle after RD_ADDR.
// Backpressure: none; transactions during a clear or with RW=1 are dropped and flagged on ERR.
module lcd_bus_receiver (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_CHAR,
  output logic [4:0] AC,
  output logic       DISP_ON,
  output logic       BUSY,
  output logic       WR_STB,
  output logic       ERR
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic       e_q, rs_q, rw_q;
  logic [7:0] data_q;
  logic       fall;
  logic [4:0] clr_idx, clr_idx_nxt, ac_nxt;
  logic       inc, inc_nxt, disp_nxt, cg_mode, cg_nxt;
  logic       wr_stb_nxt, err_nxt;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdat;
  logic [7:0] mem [32];

  // Track E for edge detection and hold the bus fields from the last E-high cycle.
  always_ff @(posedge CLK) begin
    if (RESETN) e_q <= 1'b0;
    else        e_q <= LCD_E;
    if (LCD_E) begin
      rs_q   <= LCD_RS;
      rw_q   <= LCD_RW;
      data_q <= LCD_DATA;
    end
  end

  assign fall = e_q & ~LCD_E;
  assign BUSY = (state == S_CLEAR);

  // Next-state: sweep blanks through memory while clearing, otherwise decode the completed transaction.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ac_nxt      = AC;
    inc_nxt     = inc;
    disp_nxt    = DISP_ON;
    cg_nxt      = cg_mode;
    wr_stb_nxt  = 1'b0;
    err_nxt     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = clr_idx;
    mem_wdat    = 8'h20;
    if (state == S_CLEAR) begin
      mem_we      = 1'b1;
      clr_idx_nxt = clr_idx + 5'd1;
      if (clr_idx == 5'd31) state_nxt = S_IDLE;
      if (fall) err_nxt = 1'b1;
    end else if (fall) begin
      if (rw_q) begin
        err_nxt = 1'b1;
      end else if (rs_q) begin
        // Writes aimed at CGRAM are accepted on the bus but have no shadow storage.
        if (!cg_mode) begin
          mem_we     = 1'b1;
          mem_addr   = AC;
          mem_wdat   = data_q;
          ac_nxt     = inc ? AC + 5'd1 : AC - 5'd1;
          wr_stb_nxt = 1'b1;
        end
      end else begin
        casez (data_q)
          8'b1???_????: begin
            ac_nxt = {data_q[6], data_q[3:0]};
            cg_nxt = 1'b0;
          end
          8'b01??_????: cg_nxt = 1'b1;
          8'b001?_????: ;
          8'b0001_????: begin
            if (!data_q[3]) ac_nxt = data_q[2] ? AC + 5'd1 : AC - 5'd1;
          end
          8'b0000_1???: disp_nxt = data_q[2];
          8'b0000_01??: inc_nxt = data_q[1];
          8'b0000_001?: begin
            ac_nxt = 5'd0;
            cg_nxt = 1'b0;
          end
          8'b0000_0001: begin
            ac_nxt      = 5'd0;
            inc_nxt     = 1'b1;
            cg_nxt      = 1'b0;
            state_nxt   = S_CLEAR;
            clr_idx_nxt = 5'd0;
          end
          default: ;
        endcase
      end
    end
  end

  // State register and control/status registers.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state   <= S_CLEAR;
      clr_idx <= 5'd0;
      AC      <= 5'd0;
      inc     <= 1'b1;
      DISP_ON <= 1'b0;
      cg_mode <= 1'b0;
      WR_STB  <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      AC      <= ac_nxt;
      inc     <= inc_nxt;
      DISP_ON <= disp_nxt;
      cg_mode <= cg_nxt;
      WR_STB  <= wr_stb_nxt;
      ERR     <= err_nxt;
    end
  end

  // Character memory write port; reset restarts the clear so no write is needed during it.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESETN) mem[mem_addr] <= mem_wdat;
  end

  // Registered read port; a same-cycle write to the same cell returns the old value.
  always_ff @(posedge CLK) begin
    if (RESETN) RD_CHAR <= 8'h00;
    else        RD_CHAR <= mem[RD_ADDR];
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: directed bus transactions with hand-computed expectations.
// Latency: expectations are queued at issue time and retired by a negedge monitor.
// Backpressure: bench spaces falling edges of E two cycles apart.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] ac;
  logic       disp_on, busy, wr_stb, err;

  always #5 clk = ~clk;

  lcd_bus_receiver dut (
    .CLK(clk), .RESETN(rst), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_DATA(lcd_data), .RD_ADDR(rd_addr), .RD_CHAR(rd_char), .AC(ac),
    .DISP_ON(disp_on), .BUSY(busy), .WR_STB(wr_stb), .ERR(err)
  );

  typedef struct packed {
    logic [7:0] ch;
    logic       chk_ch;
    logic [4:0] ac;
    logic       disp;
    logic       busy;
  } probe_t;

  logic [1:0] ev_q [$];     // {WR_STB, ERR} pulses expected, in order
  probe_t     pr_q [$];
  int         busy_q [$];   // expected BUSY run lengths
  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_cnt = 0;
  logic       rd_req   = 1'b0;
  logic       rd_pend  = 1'b0;
  logic       end_req  = 1'b0;
  logic       end_ack  = 1'b0;

  always @(posedge clk) rd_pend <= rd_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: retire queued expectations whenever the DUT presents a pulse, read data or a BUSY run.
  always @(negedge clk) begin
    probe_t     p;
    logic [1:0] ev;
    if (wr_stb === 1'b1 || err === 1'b1) begin
      if (ev_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, wr_stb, err}, 32'd0);
      end else begin
        ev = ev_q.pop_front();
        check("pulse", {30'd0, wr_stb, err}, {30'd0, ev});
      end
    end
    if (rd_pend) begin
      if (pr_q.size() == 0) begin
        check("probe_queue", 32'd0, 32'd1);
      end else begin
        p = pr_q.pop_front();
        if (p.chk_ch) check("rd_char", {24'd0, rd_char}, {24'd0, p.ch});
        check("ac_disp_busy", {25'd0, ac, disp_on, busy}, {25'd0, p.ac, p.disp, p.busy});
      end
    end
    if (rst === 1'b1) begin
      busy_cnt = 0;
    end else if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy === 1'b0 && busy_cnt > 0) begin
      if (busy_q.size() == 0) check("unexpected_busy_run", busy_cnt, 32'd0);
      else                    check("busy_len", busy_cnt, busy_q.pop_front());
      busy_cnt = 0;
    end
    if (end_req && !end_ack) begin
      check("pending_pulses", ev_q.size(), 32'd0);
      check("pending_probes", pr_q.size(), 32'd0);
      check("pending_busy", busy_q.size(), 32'd0);
      end_ack = 1'b1;
    end
  end

  // One bus transaction: E high one cycle, then low one cycle.
  task automatic xact(input logic rs, input logic rw, input logic [7:0] d);
    lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    @(posedge clk); #1;
    lcd_e = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_char(input logic [7:0] d);
    ev_q.push_back(2'b10);
    xact(1'b1, 1'b0, d);
  endtask

  task automatic probe(input logic [4:0] a, input logic chk, input logic [7:0] ch,
                       input logic [4:0] exp_ac, input logic exp_disp, input logic exp_busy);
    pr_q.push_back('{ch: ch, chk_ch: chk, ac: exp_ac, disp: exp_disp, busy: exp_busy});
    rd_addr = a;
    rd_req  = 1'b1;
    @(posedge clk); #1;
    rd_req  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] msg [5];

  initial begin
    msg = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34};
    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
    @(posedge clk); #1;

    // Reset state, then power-up clear of 32 cycles.
    busy_q.push_back(32);
    probe(5'd0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1);
    rst = 1'b0;
    idle(34);
    for (int i = 0; i < 32; i++) probe(i[4:0], 1'b1, 8'h20, 5'd0, 1'b0, 1'b0);

    // Display on, home, "12:34".
    xact(1'b0, 1'b0, 8'h0C);
    xact(1'b0, 1'b0, 8'h80);
    for (int k = 0; k < 5; k++) wr_char(msg[k]);
    for (int k = 0; k < 5; k++) probe(k[4:0], 1'b1, msg[k], 5'd5, 1'b1, 1'b0);

    // Wrap 31->0 on increment, then 0->31 on decrement.
    xact(1'b0, 1'b0, 8'hCF);
    wr_char(8'h41);
    wr_char(8'h42);
    probe(5'd31, 1'b1, 8'h41, 5'd1, 1'b1, 1'b0);
    probe(5'd0,  1'b1, 8'h42, 5'd1, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'h04);
    xact(1'b0, 1'b0, 8'h80);
    wr_char(8'h43);
    probe(5'd0, 1'b1, 8'h43, 5'd31, 1'b1, 1'b0);

    // Cursor shifts, ignored D[5:4] in set-address, display off/on.
    xact(1'b0, 1'b0, 8'h14);
    probe(5'd0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'h10);
    xact(1'b0, 1'b0, 8'h18);
    probe(5'd0, 1'b0, 8'h00, 5'd31, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'hB5);
    probe(5'd0, 1'b0, 8'h00, 5'd5, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'h08);
    probe(5'd0, 1'b0, 8'h00, 5'd5, 1'b0, 1'b0);
    xact(1'b0, 1'b0, 8'h0C);

    // Clear command; a write arriving mid-clear is dropped with ERR.
    busy_q.push_back(32);
    xact(1'b0, 1'b0, 8'h01);
    idle(2);
    ev_q.push_back(2'b01);
    xact(1'b1, 1'b0, 8'h39);
    idle(40);
    for (int i = 0; i < 32; i++) probe(i[4:0], 1'b1, 8'h20, 5'd0, 1'b1, 1'b0);

    // RW=1 drops; CGRAM-mode data discarded; return home restores DDRAM writes.
    ev_q.push_back(2'b01);
    xact(1'b0, 1'b1, 8'h08);
    ev_q.push_back(2'b01);
    xact(1'b1, 1'b1, 8'h99);
    probe(5'd0, 1'b1, 8'h20, 5'd0, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'h40);
    xact(1'b1, 1'b0, 8'h55);
    probe(5'd0, 1'b1, 8'h20, 5'd0, 1'b1, 1'b0);
    xact(1'b0, 1'b0, 8'h02);
    wr_char(8'h55);
    probe(5'd0, 1'b1, 8'h55, 5'd1, 1'b1, 1'b0);

    // Reset pulse partway through a clear restarts a full 32-cycle clear.
    xact(1'b0, 1'b0, 8'h01);
    idle(10);
    busy_q.push_back(32);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    probe(5'd0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1);
    idle(40);
    probe(5'd0,  1'b1, 8'h20, 5'd0, 1'b0, 1'b0);
    probe(5'd31, 1'b1, 8'h20, 5'd0, 1'b0, 1'b0);

    idle(3);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_ack; k++) @(posedge clk);
    if (!end_ack) $display("FAIL end_handshake: monitor did not acknowledge");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the 8-bit character-LCD write bus (E/RS/RW/DATA) that the LCD controller drives. The block decodes each bus transaction as the panel would and keeps a shadow 2x16 character memory, an address counter and display state. Its read port lets the testbench or an on-chip self-check compare the displayed time and meridian against Time_cal. It sits beside the LCD pins on the same clock as the controller.

## Interface
- No parameters; geometry fixed at 2 lines x 16 characters (32 cells).
- CLK  in  1  system clock; all state on rising edge.
- RESETN  in  1  synchronous, active-high reset (1 = reset), sampled on rising CLK.
- LCD_E  in  1  bus enable; a transaction completes on its falling edge.
- LCD_RS  in  1  0 = command, 1 = character data.
- LCD_RW  in  1  0 = write; 1 = read (unsupported, flagged).
- LCD_DATA  in  8  command or character byte.
- RD_ADDR  in  5  shadow-memory read index; 0-15 line 1, 16-31 line 2.
- RD_CHAR  out  8  character at RD_ADDR, registered.
- AC  out  5  current address counter (cell index).
- DISP_ON  out  1  display-on bit from the last display-control command.
- BUSY  out  1  clear sequence in progress.
- WR_STB  out  1  one-cycle pulse when a character is stored.
- ERR  out  1  one-cycle pulse on a dropped transaction (RW=1 or arrival while BUSY).

## Operation
- E edge detect: register E_q each cycle. Register RS/RW/DATA every cycle E=1. Falling edge = E_q=1 and LCD_E=0. The transaction uses the values captured in the last E-high cycle.
- FSM states: CLEAR and IDLE.
  - CLEAR: writes 0x20 to cell clr_idx, clr_idx += 1; after cell 31 go to IDLE. BUSY=1 throughout CLEAR.
  - IDLE: executes transactions.
- Reset enters CLEAR with clr_idx=0, AC=0, inc=1, DISP_ON=0, cg_mode=0, WR_STB=0, ERR=0, RD_CHAR=0x00.
- RW=1 transaction: nothing executes; ERR pulses.
- Any transaction in CLEAR: dropped; ERR pulses. The clear continues unaffected.
- Command decode (RS=0), priority by highest set bit:
  - 0x80-0xFF, set DDRAM address: AC={D[6],D[3:0]}; D[5:4] ignored; cg_mode=0.
  - 0x40-0x7F, CGRAM address: cg_mode=1; AC unchanged.
  - 0x20-0x3F, function set: no effect.
  - 0x10-0x1F, shift: if D[3]=0, AC moves +1 (D[2]=1) or -1 (D[2]=0), mod 32; if D[3]=1, no effect.
  - 0x08-0x0F, display control: DISP_ON=D[2].
  - 0x04-0x07, entry mode: inc=D[1]; D[0] ignored.
  - 0x02-0x03, return home: AC=0, cg_mode=0.
  - 0x01, clear: AC=0, inc=1, cg_mode=0, enter CLEAR with clr_idx=0.
  - 0x00: no effect.
- Data write (RS=1, RW=0):
  - cg_mode=0: mem[AC]=DATA; AC = AC+1 if inc else AC-1, mod 32; WR_STB pulses.
  - cg_mode=1: data discarded; AC unchanged; no WR_STB, no ERR.
- Wrap-around: 15->16 continues onto line 2; 31->0 on increment; 0->31 on decrement.
- RD_CHAR=mem[RD_ADDR]. If the read and a write hit the same cell in the same cycle, RD_CHAR returns the old value.

## Timing
- A falling edge detected in cycle n is executed at the rising edge ending cycle n. In cycle n+1:
  - memory, AC, DISP_ON and state show the result;
  - WR_STB/ERR are high for exactly cycle n+1.
- RD_CHAR latency: 1 cycle from RD_ADDR.
- CLEAR duration: 32 cycles. BUSY rises the cycle after reset or the 0x01 edge and falls after cell 31 is written.
- Reset asserted mid-CLEAR or mid-transaction restarts CLEAR from 0. An E falling edge during reset is lost.
- Back-to-back transactions need at least 2 cycles between falling edges (E high at least 1 cycle).

## Test plan
- Reset, release, wait 32 cycles -> BUSY high 32 cycles then 0; all 32 cells read 0x20; AC=0; DISP_ON=0.
- Cmd 0x0C, cmd 0x80, data "12:34" -> DISP_ON=1; cells 0-4 = 0x31,0x32,0x3A,0x33,0x34; AC=5; five WR_STB pulses.
- Cmd 0xCF, data 'A','B' -> cell 31=0x41, cell 0=0x42, AC=1. Then cmd 0x04, cmd 0x80, data 'C' -> cell 0=0x43, AC=31.
- Cmd 0x01, then a data write 3 cycles later -> ERR pulses once; all cells 0x20 after 32 cycles; AC=0.
- RW=1 transaction -> ERR pulse, no state change. Cmd 0x40, data 0x55 -> no WR_STB, cells unchanged. Cmd 0x02, data 0x55 -> cell 0=0x55.
- Reset asserted for 1 cycle at cell 10 of a clear -> BUSY restarts and lasts a full 32 cycles; AC=0.
